// File: rtl/ecg_mem_reader.sv
// Read-side controller for the ECG sample BRAM: fetches a contiguous block of words
// and streams them out through a small FWFT skid FIFO that covers the BRAM read latency.
module ecg_mem_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_length,
    output logic [ADDR_W-1:0] o_addrb,
    output logic              o_enb,
    output logic              o_web,
    output logic [DATA_W-1:0] o_dinb,
    input  logic [DATA_W-1:0] i_doutb,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_dout_last,
    output logic              o_busy,
    output logic              o_done
);

    // state   | meaning
    // S_IDLE  | waiting for a start command
    // S_READ  | issuing BRAM reads, throttled by FIFO space
    // S_DRAIN | all reads issued, waiting for the last word to be popped
    // S_DONE  | one-cycle completion pulse
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W + 1)'(DEPTH);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_popped;
    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  r_count;
    logic [RD_LAT-1:0] r_lat;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;

    logic [CNT_W:0] w_occ;
    logic           w_issue;
    logic           w_push;
    logic           w_valid;
    logic           w_pop;
    logic           w_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy deliberately ignores a same-cycle pop so the issue path stays short.
    assign w_occ   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue = (r_state == S_READ) && (r_remaining != '0) && (w_occ < OCC_MAX);
    assign w_push  = r_lat[RD_LAT-1];
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && i_dout_ready;
    assign w_last  = w_valid && (r_popped == r_len - (ADDR_W + 1)'(1));

    assign o_enb        = w_issue;
    assign o_addrb      = r_addr;
    assign o_web        = 1'b0;
    assign o_dinb       = '0;
    assign o_dout       = w_valid ? r_mem[r_rd] : '0;
    assign o_dout_valid = w_valid;
    assign o_dout_last  = w_last;
    assign o_busy       = (r_state == S_READ) || (r_state == S_DRAIN);
    assign o_done       = (r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_popped    <= '0;
            r_inflight  <= '0;
            r_count     <= '0;
            r_lat       <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
        end else begin
            r_lat      <= (r_lat << 1) | RD_LAT'(w_issue);
            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd     <= ptr_inc(r_rd);
                r_popped <= r_popped + (ADDR_W + 1)'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_length != '0) begin
                            r_addr      <= i_base_addr;
                            r_remaining <= i_length;
                            r_len       <= i_length;
                            r_popped    <= '0;
                            r_state     <= S_READ;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - (ADDR_W + 1)'(1);
                        if (r_remaining == (ADDR_W + 1)'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_doutb;
        end
    end

endmodule

// File: tb/tb_ecg_mem_reader.sv
// Directed self-checking bench for ecg_mem_reader with a 2-cycle-latency BRAM model
// preloaded with mem[a] = a.
module tb_ecg_mem_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base = '0;
    logic [12:0] len = '0;
    logic [11:0] addrb;
    logic        enb;
    logic        web;
    logic [31:0] dinb;
    logic [31:0] doutb = '0;
    logic [31:0] dout;
    logic        dvalid;
    logic        dready = 1'b0;
    logic        dlast;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [4096];
    logic [31:0] bram_p1 = '0;
    int          max_count = 0;
    int          ovf_events = 0;

    ecg_mem_reader #(.ADDR_W(12), .DATA_W(32), .RD_LAT(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base),
        .i_length     (len),
        .o_addrb      (addrb),
        .o_enb        (enb),
        .o_web        (web),
        .o_dinb       (dinb),
        .i_doutb      (doutb),
        .o_dout       (dout),
        .o_dout_valid (dvalid),
        .i_dout_ready (dready),
        .o_dout_last  (dlast),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Two-stage BRAM read pipeline: address sampled, then output register.
    always @(posedge clk) begin
        if (enb) bram_p1 <= mem[addrb];
        doutb <= bram_p1;
    end

    always @(posedge clk) begin
        if (int'(dut.r_count) > max_count) max_count = int'(dut.r_count);
        if (dut.w_push && (dut.r_count == 3'd4) && !dut.w_pop) ovf_events++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if ({enb, dvalid, dlast, busy, done, web} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000000", {enb, dvalid, dlast, busy, done, web});
        end
        total++;
        if (addrb !== 12'h000) begin
            bad++;
            $display("FAIL reset_addrb got=%h exp=000", addrb);
        end
        total++;
        if (dout !== 32'h0) begin
            bad++;
            $display("FAIL reset_dout got=%h exp=0", dout);
        end
        total++;
        if (dinb !== 32'h0) begin
            bad++;
            $display("FAIL reset_dinb got=%h exp=0", dinb);
        end
        step();
    endtask

    task automatic test_basic();
        logic       e_enb, e_valid, e_last, e_busy, e_done;
        dready = 1'b1;
        base   = 12'h010;
        len    = 13'd4;
        start  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            e_enb   = (k >= 1) && (k <= 4);
            e_valid = (k >= 4) && (k <= 7);
            e_last  = (k == 7);
            e_busy  = (k >= 1) && (k <= 7);
            e_done  = (k == 8);
            total++;
            if ({enb, dvalid, dlast, busy, done} !== {e_enb, e_valid, e_last, e_busy, e_done}) begin
                bad++;
                $display("FAIL basic_ctl k=%0d got=%b exp=%b", k, {enb, dvalid, dlast, busy, done},
                         {e_enb, e_valid, e_last, e_busy, e_done});
            end
            if (e_enb) begin
                total++;
                if (addrb !== 12'(12'h010 + k - 1)) begin
                    bad++;
                    $display("FAIL basic_addr k=%0d got=%h exp=%h", k, addrb, 12'(12'h010 + k - 1));
                end
            end
            if (e_valid) begin
                total++;
                if (dout !== 32'(32'h10 + k - 4)) begin
                    bad++;
                    $display("FAIL basic_data k=%0d got=%h exp=%h", k, dout, 32'(32'h10 + k - 4));
                end
            end
            step();
            start = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int  issued = 0;
        int  popped = 0;
        bit  seen_done = 0;
        max_count  = 0;
        ovf_events = 0;
        base  = 12'h000;
        len   = 13'd16;
        start = 1'b1;
        for (int c = 0; c < 400 && !seen_done; c++) begin
            dready = (c >= 5 && c < 15) ? 1'b0 : 1'($urandom_range(0, 1));
            if (enb) begin
                total++;
                if (addrb !== 12'(issued)) begin
                    bad++;
                    $display("FAIL bp_addr got=%h exp=%h", addrb, 12'(issued));
                end
                issued++;
            end
            if (c == 14) begin
                total++;
                if ({enb, dvalid} !== 2'b01 || issued - popped != 4) begin
                    bad++;
                    $display("FAIL bp_stall got enb=%b valid=%b outstanding=%0d exp enb=0 valid=1 outstanding=4",
                             enb, dvalid, issued - popped);
                end
            end
            if (dvalid) begin
                total++;
                if (dout !== 32'(popped)) begin
                    bad++;
                    $display("FAIL bp_data got=%h exp=%h", dout, 32'(popped));
                end
                if (dready) begin
                    total++;
                    if (dlast !== (popped == 15)) begin
                        bad++;
                        $display("FAIL bp_last idx=%0d got=%b exp=%b", popped, dlast, popped == 15);
                    end
                    popped++;
                end
            end
            if (done) seen_done = 1;
            step();
            start = 1'b0;
        end
        dready = 1'b1;
        total++;
        if (!seen_done || issued != 16 || popped != 16) begin
            bad++;
            $display("FAIL bp_totals got done=%0d issued=%0d popped=%0d exp done=1 issued=16 popped=16",
                     seen_done, issued, popped);
        end
        total++;
        if (max_count > 4 || ovf_events != 0) begin
            bad++;
            $display("FAIL bp_fifo_bound got max=%0d ovf=%0d exp max<=4 ovf=0", max_count, ovf_events);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_a [4];
        int  issued = 0;
        int  popped = 0;
        bit  seen_done = 0;
        exp_a[0] = 12'hFFE;
        exp_a[1] = 12'hFFF;
        exp_a[2] = 12'h000;
        exp_a[3] = 12'h001;
        dready = 1'b1;
        base   = 12'hFFE;
        len    = 13'd4;
        start  = 1'b1;
        for (int c = 0; c < 30 && !seen_done; c++) begin
            if (enb && issued < 4) begin
                total++;
                if (addrb !== exp_a[issued]) begin
                    bad++;
                    $display("FAIL wrap_addr i=%0d got=%h exp=%h", issued, addrb, exp_a[issued]);
                end
                issued++;
            end
            if (dvalid && popped < 4) begin
                total++;
                if (dout !== {20'h0, exp_a[popped]} || dlast !== (popped == 3)) begin
                    bad++;
                    $display("FAIL wrap_data i=%0d got=%h/%b exp=%h/%b", popped, dout, dlast,
                             {20'h0, exp_a[popped]}, popped == 3);
                end
                popped++;
            end
            if (done) seen_done = 1;
            step();
            start = 1'b0;
        end
        total++;
        if (!seen_done || issued != 4 || popped != 4) begin
            bad++;
            $display("FAIL wrap_totals got done=%0d issued=%0d popped=%0d exp 1/4/4", seen_done, issued, popped);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        int  issued = 0;
        int  popped = 0;
        bit  seen_done = 0;
        dready = 1'b1;
        base   = 12'h123;
        len    = 13'd0;
        start  = 1'b1;
        step();
        start = 1'b0;
        total++;
        if ({done, busy, enb} !== 3'b100) begin
            bad++;
            $display("FAIL zero_done got done/busy/enb=%b exp=100", {done, busy, enb});
        end
        step();
        total++;
        if ({done, busy, enb, dvalid} !== 4'b0000) begin
            bad++;
            $display("FAIL zero_after got done/busy/enb/valid=%b exp=0000", {done, busy, enb, dvalid});
        end
        base  = 12'h100;
        len   = 13'd6;
        start = 1'b1;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (c == 3) begin
                start = 1'b1;
                base  = 12'h300;
                len   = 13'd2;
            end else if (c > 0) begin
                start = 1'b0;
            end
            if (enb) begin
                total++;
                if (addrb !== 12'(12'h100 + issued)) begin
                    bad++;
                    $display("FAIL ign_addr got=%h exp=%h", addrb, 12'(12'h100 + issued));
                end
                issued++;
            end
            if (dvalid) begin
                total++;
                if (dout !== 32'(32'h100 + popped) || dlast !== (popped == 5)) begin
                    bad++;
                    $display("FAIL ign_data got=%h/%b exp=%h/%b", dout, dlast, 32'(32'h100 + popped), popped == 5);
                end
                popped++;
            end
            if (done) begin
                seen_done = 1;
                start = 1'b1;
            end
            step();
        end
        start = 1'b0;
        total++;
        if ({busy, enb, done} !== 3'b000) begin
            bad++;
            $display("FAIL ign_in_done got busy/enb/done=%b exp=000", {busy, enb, done});
        end
        total++;
        if (!seen_done || issued != 6 || popped != 6) begin
            bad++;
            $display("FAIL ign_totals got done=%0d issued=%0d popped=%0d exp 1/6/6", seen_done, issued, popped);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int  popped = 0;
        int  got2 = 0;
        bit  seen_done = 0;
        bit  stray = 0;
        dready = 1'b1;
        base   = 12'h000;
        len    = 13'd100;
        start  = 1'b1;
        for (int c = 0; c < 60 && popped < 20; c++) begin
            if (dvalid) popped++;
            if (popped == 20) rst = 1'b1;
            step();
            start = 1'b0;
        end
        rst = 1'b0;
        total++;
        if ({enb, dvalid, dlast, busy, done} !== 5'b0 || addrb !== 12'h0 || dout !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_outputs got ctl=%b addr=%h dout=%h exp ctl=00000 addr=000 dout=0",
                     {enb, dvalid, dlast, busy, done}, addrb, dout);
        end
        for (int c = 0; c < 8; c++) begin
            if (dvalid || enb || done || busy) stray = 1;
            step();
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL rstmid_stray got activity=1 exp=0");
        end
        base  = 12'h200;
        len   = 13'd2;
        start = 1'b1;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (dvalid) begin
                total++;
                if (dout !== 32'(32'h200 + got2) || dlast !== (got2 == 1)) begin
                    bad++;
                    $display("FAIL rstmid_data got=%h/%b exp=%h/%b", dout, dlast, 32'(32'h200 + got2), got2 == 1);
                end
                got2++;
            end
            if (done) seen_done = 1;
            step();
            start = 1'b0;
        end
        total++;
        if (!seen_done || got2 != 2) begin
            bad++;
            $display("FAIL rstmid_totals got done=%0d words=%0d exp 1/2", seen_done, got2);
        end
    endtask

    task automatic test_full_memory();
        int prints = 0;
        dready = 1'b1;
        base   = 12'h000;
        len    = 13'd4096;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        total++;
        if (dvalid !== 1'b0) begin
            bad++;
            $display("FAIL full_early_valid got=%b exp=0", dvalid);
        end
        step();
        for (int i = 0; i < 4096; i++) begin
            total++;
            if (dvalid !== 1'b1 || dout !== 32'(i) || dlast !== (i == 4095)) begin
                bad++;
                if (prints < 5) begin
                    prints++;
                    $display("FAIL full_word i=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             i, dvalid, dout, dlast, 32'(i), i == 4095);
                end
            end
            step();
        end
        total++;
        if ({done, busy, dvalid} !== 3'b100) begin
            bad++;
            $display("FAIL full_done got done/busy/valid=%b exp=100", {done, busy, dvalid});
        end
        step();
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 32'(a);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_ignored_start();
        test_reset_mid();
        test_full_memory();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecg_mem_reader.md
# ecg_mem_reader

Read-side controller for the ECG sample BRAM (32-bit × 4096, port B). On a start command it fetches a contiguous block of samples from a base address, absorbs the BRAM's fixed read latency, and delivers the words in order on a valid/ready stream to the downstream processing chain. Sink backpressure is absorbed by an internal skid FIFO sized so that no in-flight read is ever lost.

## Interface

- ADDR_W, 12, BRAM address width; address space 2^ADDR_W words
- DATA_W, 32, sample word width
- RD_LAT, 2, BRAM read latency in cycles, from `Enb` asserted to `Doutb` valid; legal range 1–4
- Clk  input  1  single clock, rising edge; the BRAM port B clock is also `Clk`
- Rst  input  1  synchronous, active-high reset
- Start  input  1  one-cycle command pulse; sampled only in IDLE
- Base_addr  input  ADDR_W  first word address; sampled with `Start`
- Length  input  ADDR_W+1  number of words, 0..4096; sampled with `Start`
- Addrb  output  ADDR_W  BRAM port B address
- Enb  output  1  BRAM port B enable; one read per cycle in which it is high
- Web  output  1  BRAM port B write enable; constant 0
- Dinb  output  DATA_W  constant 0
- Doutb  input  DATA_W  BRAM port B read data
- Dout  output  DATA_W  stream data
- Dout_valid  output  1  stream valid
- Dout_ready  input  1  stream ready from sink
- Dout_last  output  1  high together with `Dout_valid` on the final word of the block
- Busy  output  1  high in READ and DRAIN
- Done  output  1  one-cycle pulse at the end of the block

## Operation

- States: IDLE, READ, DRAIN, DONE.
- IDLE: if `Start` is high and `Length` > 0, latch the base address into the address counter and `Length` into the remaining counter, then go to READ. If `Start` is high and `Length` = 0, go straight to DONE with no reads issued.
- READ: issue a read (`Enb`=1, `Addrb`=address counter) when remaining > 0 and fifo_count + inflight < DEPTH, where DEPTH = RD_LAT+2. The count does not credit a same-cycle pop.
  - On each issue: address counter +1, modulo 2^ADDR_W, so address 0xFFF wraps to 0x000. Remaining −1. Inflight +1.
  - When the last read is issued, go to DRAIN.
- Read-return tracking: a delay line of length RD_LAT carries the `Enb` flag. When it emerges, `Doutb` is pushed into the FIFO and inflight is decremented.
- FIFO: first-word-fall-through, DEPTH entries.
  - `Dout`/`Dout_valid` show the head entry.
  - A pop occurs when `Dout_valid` and `Dout_ready` are both high.
  - A push and a pop in the same cycle leave the count unchanged.
  - The FIFO never overflows by construction. An overflow is a design error; the bench asserts it never happens.
- Dout_last: high when the head entry is the word whose index is Length−1. Implemented as a delivered-word counter compared against the latched Length.
- DRAIN: wait until the last word has been popped, then go to DONE.
- DONE: `Done`=1 for exactly one cycle, `Busy`=0, then go to IDLE. `Start` is ignored in DONE.
- `Start` in READ, DRAIN or DONE is ignored. No queuing of commands.
- Throughput: with `Dout_ready` held high, one word per cycle is sustained. Steady state holds RD_LAT words in flight plus 1 in the FIFO, which stays below DEPTH.

## Timing

- Reset values (registered on the `Rst` edge): state=IDLE, `Enb`=0, `Addrb`=0, `Dout_valid`=0, `Dout_last`=0, `Busy`=0, `Done`=0, `Dout`=0, FIFO empty, inflight=0, latency delay line cleared.
- `Rst` mid-operation: the block aborts. In-flight BRAM data returning after reset is discarded because the delay line is cleared. No `Done` pulse is produced.
- `Start` sampled in cycle N, `Length` > 0:
  - `Busy`=1 from cycle N+1.
  - First `Enb` in cycle N+1 with `Addrb`=Base_addr.
  - First `Dout_valid` in cycle N+RD_LAT+2. This is N+4 at the default RD_LAT.
- Read issued in cycle t: `Doutb` is captured at the end of cycle t+RD_LAT, and the word is visible on `Dout` from cycle t+RD_LAT+1.
- Last word handshaked in cycle M: `Busy`=0 and `Done`=1 in cycle M+1. IDLE in M+2, where a new `Start` is accepted.
- `Length`=0 with `Start` in cycle N: `Done`=1 in N+1. `Busy` stays 0 and `Enb` stays 0.
- `Dout`, `Dout_valid` and `Dout_last` are stable while `Dout_valid`=1 and `Dout_ready`=0.

## Test plan

- Basic: BRAM preloaded with mem[a]=a; Base=0x010, Length=4, `Dout_ready`=1 → `Enb` high for cycles N+1..N+4. `Dout` = 0x10, 0x11, 0x12, 0x13 in cycles N+4..N+7, with `Dout_last` only on 0x13. `Done` in N+8.
- Backpressure: Base=0x000, Length=16; `Dout_ready` random at 50%, plus one 10-cycle stall → all 16 words in order, none duplicated or dropped. fifo_count never exceeds 4. `Enb` stalls while the FIFO is full.
- Wrap-around: Base=0xFFE, Length=4 → `Addrb` sequence 0xFFE, 0xFFF, 0x000, 0x001. Data matches those addresses.
- Zero length and ignored start: `Length`=0 → `Done` the next cycle, no `Enb`. Then a second `Start` pulsed mid-block → no effect on addresses or word count.
- Reset mid-block: Length=100, `Rst` pulsed after 20 words → all outputs at reset values the following cycle, no stray `Dout_valid` afterwards. A new block Base=0x200, Length=2 then delivers mem[0x200], mem[0x201] correctly.
- Full memory: Base=0x000, Length=4096, `Dout_ready`=1 → 4096 consecutive cycles of `Dout_valid`. `Dout_last` on word 0xFFF only. `Done` one cycle after it.
